// File: rtl/quad_pkg.sv
// Shared types, Gray-code constants and the transition classifier for the
// quadrature step decoder.
package quad_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;

  // Pairs are {a, b}; "up" walks 00 -> 10 -> 11 -> 01 -> 00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t      res;
    logic [1:0] up_next;
    logic [1:0] dn_next;
    res = '0;
    case (prev)
      Q00:     up_next = Q10;
      Q10:     up_next = Q11;
      Q11:     up_next = Q01;
      default: up_next = Q00;
    endcase
    case (prev)
      Q00:     dn_next = Q01;
      Q01:     dn_next = Q11;
      Q11:     dn_next = Q10;
      default: dn_next = Q00;
    endcase
    if (cur == up_next) begin
      res.valid = 1'b1;
      res.dir   = 1'b1;
    end else if (cur == dn_next) begin
      res.valid = 1'b1;
      res.dir   = 1'b0;
    end else if (cur != prev) begin
      res.illegal = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/quadrature_step_decoder_filter.sv
// One encoder channel: metastability synchroniser followed by a
// run-length glitch filter with a direct-load path used during FILL.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  input  logic load_i,
  output logic filt_o,
  output logic filt_next_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_bit;

  // A load takes the value the last sync stage captures on this same edge,
  // so the filter and synchroniser agree as soon as RUN begins.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    sync_bit = sync_q[SYNC_STAGES-1];
    cnt_d    = '0;
    filt_d   = filt_q;
    if (load_i) begin
      filt_d = sync_d[SYNC_STAGES-1];
    end else if (sync_bit != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = sync_bit;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o      = filt_q;
  assign filt_next_o = filt_d;

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B front end: filtered channels feed a FILL/RUN FSM and a
// Gray-code decoder producing registered step, direction and sticky error.
module quadrature_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic clear_err_i,
  output logic step_o,
  output logic up_down_o,
  output logic err_o
);

  import quad_pkg::*;

  localparam int FILL_W = $clog2(SYNC_STAGES) + 1;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0]        prev_q, prev_d;
  logic              step_q, step_d;
  logic              up_down_q, up_down_d;
  logic              err_q, err_d;
  logic              load;
  logic              fa, fb, fa_next, fb_next;
  step_t             dec;

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_i      (enc_a),
    .load_i     (load),
    .filt_o     (fa),
    .filt_next_o(fa_next)
  );

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_i      (enc_b),
    .load_i     (load),
    .filt_o     (fb),
    .filt_next_o(fb_next)
  );

  // Illegal-transition set is applied after clear so that set wins.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    up_down_d  = up_down_q;
    err_d      = err_q;
    load       = 1'b0;
    dec        = decode_step(prev_q, {fa, fb});
    if (clear_err_i) begin
      err_d = 1'b0;
    end
    case (state_q)
      FILL: begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
        if (fill_cnt_q == FILL_W'(SYNC_STAGES - 1)) begin
          load    = 1'b1;
          prev_d  = {fa_next, fb_next};
          state_d = RUN;
        end
      end
      RUN: begin
        prev_d = {fa, fb};
        if (dec.valid) begin
          step_d    = 1'b1;
          up_down_d = dec.dir;
        end
        if (dec.illegal) begin
          err_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      prev_q     <= Q00;
      step_q     <= 1'b0;
      up_down_q  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      err_q      <= err_d;
    end
  end

  assign step_o    = step_q;
  assign up_down_o = up_down_q;
  assign err_o     = err_q;

endmodule

// File: doc/quadrature_step_decoder.md
Name: quadrature_step_decoder

Overview:
Front-end stage that converts a 2-channel quadrature encoder (A/B) into step/direction commands. It drives the 8-bit up/down counter stage: up_down_o feeds the counter's direction input and step_o is the counter's count enable. It contains input synchronisers, per-channel glitch filters, an init/run FSM and a Gray-code transition decoder with illegal-transition detection.

Parameters:
SYNC_STAGES  2  flops per channel in the metastability synchroniser (legal values are 2 or more)
FILTER_LEN   3  consecutive equal samples needed before a filtered channel changes (legal values are 1 to 15)

Ports:
clock        input   1  rising-edge clock
reset_n      input   1  reset, asynchronous assert, active low
enc_a        input   1  raw encoder channel A, asynchronous to clock
enc_b        input   1  raw encoder channel B, asynchronous to clock
clear_err_i  input   1  clears sticky err_o
step_o       output  1  one-cycle pulse per legal quadrature edge
up_down_o    output  1  direction of the last legal step: 1 = increment, 0 = decrement
err_o        output  1  sticky flag for an illegal transition (both filtered bits change together)

Behaviour:
- Reset (reset_n=0, asynchronous): all synchroniser flops, filter counters and filtered bits go to 0; FSM goes to FILL; step_o=0, up_down_o=1, err_o=0.
- Synchroniser: a plain shift chain of SYNC_STAGES flops per channel; sa/sb are the last stage.
- Glitch filter (per channel):
  - The counter resets to 0 whenever the sync value equals the filtered value.
  - Otherwise the counter increments each cycle; on reaching FILTER_LEN-1, the filtered bit takes the sync value and the counter resets.
  - Pulses shorter than FILTER_LEN cycles at the sync output are discarded.
- FSM states: FILL and RUN.
  - FILL: a counter runs for SYNC_STAGES cycles after reset release. On the last FILL cycle, filtered bits load directly from sa/sb, then the FSM goes to RUN. No step_o or err_o is produced during FILL.
  - RUN: the decoder compares the current filtered pair {fa,fb} with the registered previous pair every cycle.
- Decode in RUN, prev to cur:
  - Up (increment): 00→10, 10→11, 11→01, 01→00. Produces step_o=1 and up_down_o=1.
  - Down (decrement): 00→01, 01→11, 11→10, 10→00. Produces step_o=1 and up_down_o=0.
  - Both bits changed: step_o=0, err_o set to 1, up_down_o unchanged; prev still updates to the new pair.
  - No change: step_o=0.
- Outputs are registered. step_o and the new up_down_o appear together, one cycle after the filtered change.
  - Total latency from a raw edge to step_o is SYNC_STAGES+FILTER_LEN+1 cycles (6 at defaults).
- up_down_o holds its value between steps.
- err_o stays at 1 until clear_err_i=1, and clears on the next edge. If an illegal transition and clear_err_i occur in the same cycle, set wins and err_o stays 1.
- Maximum step rate is one per FILTER_LEN cycles per channel. Faster input is undefined and may flag err_o.
- Reset asserted mid-sequence: outputs clear immediately. After release, the FSM re-enters FILL, so the encoder's resting position never generates a spurious step or error.

Decomposition:
- Package quad_pkg holds:
  - the FSM state enum (FILL, RUN);
  - localparams for the 2-bit Gray codes (Q00, Q10, Q11, Q01);
  - a function returning {valid, dir, illegal} from (prev, cur).
- Sub-module quad_glitch_filter (synchroniser plus counter filter, parameterised by SYNC_STAGES and FILTER_LEN), instantiated once per channel.
- The top level holds the FSM, decoder and output registers.

Test Plan:
- Defaults, reset released with A=B=0 and held for 20 cycles → step_o=0, up_down_o=1, err_o=0 throughout.
- Forward sequence 00→10→11→01→00, each state held 8 cycles → exactly 4 step_o pulses, each with up_down_o=1; first pulse 6 cycles after the A rise.
- Reverse sequence 00→01→11→10→00 → 4 pulses with up_down_o=0 at each; up_down_o stays 0 afterwards.
- A glitch high for 2 cycles → no step. A high for 3 cycles then low → one up step followed by one down step.
- A and B toggle in the same cycle (00→11) → err_o=1 6 cycles later with no step; clear_err_i pulse → err_o=0 next cycle; clear_err_i coinciding with a new illegal transition → err_o stays 1.
- reset_n pulled low mid-sequence with A=B=1 → outputs clear immediately; after release, 30 cycles pass with no step and no err; then 11→01 → one up step.
